// File: rtl/ser40x13.sv
// 40-to-13 bit gearbox: packs 40-bit words into a left-aligned bit buffer and
// drains it 13 bits at a time, MSB first, marking slice 0 of every 40-slice frame.
module ser40x13 (
  input  logic        Cin,
  input  logic        Rst,
  input  logic [39:0] Din,
  input  logic        Dstb,
  output logic        Rdy,
  output logic [12:0] Dout,
  output logic        Dval,
  output logic        Sof
);

  localparam logic [5:0] SLICE_W   = 6'd13;
  localparam logic [5:0] WORD_W    = 6'd40;
  localparam logic [5:0] LAST_SLC  = 6'd39;

  logic [52:0] sbuf_q, sbuf_d;
  logic [52:0] shifted, ins_mask, ins_data;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  scnt_q, scnt_d;
  logic [5:0]  rem;
  logic [12:0] dout_q, dout_d;
  logic        dval_q, dval_d;
  logic        sof_q, sof_d;
  logic        emit, acc;

  // NOTE: every signal assigned in this block gets a value before any branch,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    emit     = (cnt_q >= SLICE_W);
    rem      = emit ? (cnt_q - SLICE_W) : cnt_q;
    Rdy      = (rem <= SLICE_W) && !Rst;
    acc      = Dstb && Rdy;

    // Shift out the emitted slice first, then drop the new word in directly
    // behind the surviving residue so bit order is preserved.
    shifted  = emit ? {sbuf_q[39:0], 13'd0} : sbuf_q;
    ins_mask = {{40{1'b1}}, 13'd0} >> rem;
    ins_data = {Din, 13'd0} >> rem;
    sbuf_d   = acc ? ((shifted & ~ins_mask) | ins_data) : shifted;
    cnt_d    = rem + (acc ? WORD_W : 6'd0);

    scnt_d   = scnt_q;
    dout_d   = dout_q;
    dval_d   = 1'b0;
    sof_d    = 1'b0;
    if (emit) begin
      dout_d = sbuf_q[52:40];
      dval_d = 1'b1;
      sof_d  = (scnt_q == 6'd0);
      scnt_d = (scnt_q == LAST_SLC) ? 6'd0 : (scnt_q + 6'd1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Cin) begin
    if (Rst) begin
      sbuf_q <= '0;
      cnt_q  <= '0;
      scnt_q <= '0;
      dout_q <= '0;
      dval_q <= 1'b0;
      sof_q  <= 1'b0;
    end else begin
      sbuf_q <= sbuf_d;
      cnt_q  <= cnt_d;
      scnt_q <= scnt_d;
      dout_q <= dout_d;
      dval_q <= dval_d;
      sof_q  <= sof_d;
    end
  end

  assign Dout = dout_q;
  assign Dval = dval_q;
  assign Sof  = sof_q;

endmodule

// File: tb/tb_ser40x13.sv
// Directed bench for ser40x13: a bit-queue model of the gearbox plus
// hand-computed vectors for reset, residue handling, Rdy back-pressure and framing.
module tb_ser40x13;

  logic        Cin  = 1'b0;
  logic        Rst  = 1'b1;
  logic [39:0] Din  = '0;
  logic        Dstb = 1'b0;
  logic        Rdy;
  logic [12:0] Dout;
  logic        Dval;
  logic        Sof;

  ser40x13 dut (
    .Cin  (Cin),
    .Rst  (Rst),
    .Din  (Din),
    .Dstb (Dstb),
    .Rdy  (Rdy),
    .Dout (Dout),
    .Dval (Dval),
    .Sof  (Sof)
  );

  always #5 Cin = ~Cin;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue length is the buffer occupancy.
  bit          exp_bits[$];
  int          exp_scnt;
  logic        exp_rdy, exp_dval, exp_sof, exp_chk;
  logic [12:0] exp_dout;
  logic        last_acc;
  logic        obs_rdy, obs_dval, obs_sof;
  logic [12:0] obs_dout;

  // One clock cycle: drive at the falling edge, sample Rdy 1ns later,
  // advance the model across the rising edge, sample outputs at the next fall.
  task automatic step(input logic rst, input logic dstb, input logic [39:0] din);
    int   sz;
    int   rem;
    logic emit;
    Rst  = rst;
    Dstb = dstb;
    Din  = din;
    #1;
    obs_rdy  = Rdy;
    sz       = exp_bits.size();
    emit     = (sz >= 13);
    rem      = emit ? sz - 13 : sz;
    exp_rdy  = !rst && (rem <= 13);
    last_acc = 1'b0;
    if (rst) begin
      exp_bits.delete();
      exp_scnt = 0;
      exp_dval = 1'b0;
      exp_sof  = 1'b0;
      exp_dout = '0;
      exp_chk  = 1'b1;
    end else begin
      exp_dval = emit;
      exp_sof  = emit && (exp_scnt == 0);
      exp_chk  = emit;
      if (emit) begin
        for (int i = 12; i >= 0; i--) exp_dout[i] = exp_bits.pop_front();
        exp_scnt = (exp_scnt == 39) ? 0 : exp_scnt + 1;
      end
      if (dstb && exp_rdy) begin
        for (int i = 39; i >= 0; i--) exp_bits.push_back(din[i]);
        last_acc = 1'b1;
      end
    end
    @(posedge Cin);
    @(negedge Cin);
    obs_dval = Dval;
    obs_dout = Dout;
    obs_sof  = Sof;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 40'hFF_FFFF_FFFF);
    n_vec++;
    if (obs_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rdy: got %b expected 0", obs_rdy);
    end
    n_vec++;
    if ({obs_dval, obs_sof, obs_dout} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_outputs: dval/sof/dout got %b/%b/%h expected 0/0/0000",
               obs_dval, obs_sof, obs_dout);
    end
    step(1'b0, 1'b0, 40'd0);
    n_vec++;
    if (obs_rdy !== 1'b1 || obs_dval !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: rdy/dval got %b/%b expected 1/0", obs_rdy, obs_dval);
    end
  endtask

  task automatic test_single_word();
    logic [39:0] din_t [8];
    logic        stb_t [8];
    logic        rdy_t [8];
    logic        val_t [8];
    logic [12:0] dat_t [8];
    logic        sof_t [8];
    din_t = '{40'h80_0000_0001, 40'd0, 40'd0, 40'd0, 40'd0, 40'd0, 40'd0, 40'd0};
    stb_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rdy_t = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    val_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    dat_t = '{13'h0000, 13'h1000, 13'h0000, 13'h0000, 13'h0000, 13'h0000, 13'h0000, 13'h1000};
    sof_t = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    step(1'b1, 1'b0, 40'd0);
    for (int s = 0; s < 8; s++) begin
      step(1'b0, stb_t[s], din_t[s]);
      n_vec++;
      if (obs_rdy !== rdy_t[s] || obs_dval !== val_t[s] ||
          (val_t[s] && (obs_dout !== dat_t[s] || obs_sof !== sof_t[s]))) begin
        n_err++;
        $display("FAIL single_word[%0d]: rdy/dval/dout/sof got %b/%b/%h/%b expected %b/%b/%h/%b",
                 s, obs_rdy, obs_dval, obs_dout, obs_sof, rdy_t[s], val_t[s], dat_t[s], sof_t[s]);
      end
    end
  endtask

  task automatic test_stream();
    int          sent, cyc, nslc, first_i, last_i, nsof, sof0, sof1;
    logic [39:0] w;
    logic [12:0] head;
    sent = 0; cyc = 0; nslc = 0; first_i = -1; last_i = -1;
    nsof = 0; sof0 = -1; sof1 = -1;
    step(1'b1, 1'b0, 40'd0);
    while (cyc < 120) begin
      if (sent < 26) step(1'b0, 1'b1, 40'h12_3456_7800 + 40'(sent));
      else           step(1'b0, 1'b0, 40'd0);
      if (last_acc) sent++;
      n_vec++;
      if (obs_rdy !== exp_rdy || obs_dval !== exp_dval ||
          (exp_chk && (obs_dout !== exp_dout || obs_sof !== exp_sof))) begin
        n_err++;
        $display("FAIL stream cyc %0d: rdy/dval/dout/sof got %b/%b/%h/%b expected %b/%b/%h/%b",
                 cyc, obs_rdy, obs_dval, obs_dout, obs_sof, exp_rdy, exp_dval, exp_dout, exp_sof);
      end
      if (obs_dval) begin
        if (first_i < 0) first_i = cyc;
        last_i = cyc;
        if (obs_sof) begin
          if (nsof == 0) sof0 = nslc;
          if (nsof == 1) sof1 = nslc;
          nsof++;
        end
        nslc++;
      end
      cyc++;
      if (sent == 26 && exp_bits.size() < 13 && !obs_dval) break;
    end
    n_vec++;
    if (sent != 26 || nslc != 80) begin
      n_err++;
      $display("FAIL stream_count: words/slices got %0d/%0d expected 26/80", sent, nslc);
    end
    n_vec++;
    if (last_i - first_i + 1 != nslc) begin
      n_err++;
      $display("FAIL stream_gapfree: dval span %0d cycles for %0d slices", last_i - first_i + 1, nslc);
    end
    n_vec++;
    if (nsof != 2 || sof0 != 0 || sof1 != 40) begin
      n_err++;
      $display("FAIL stream_sof: count/idx got %0d/%0d/%0d expected 2/0/40", nsof, sof0, sof1);
    end
    // Empty buffer check: the next word's first slice must be its own top bits.
    w    = 40'hA5_C3F0_0F1E;
    head = w[39:27];
    step(1'b0, 1'b1, w);
    step(1'b0, 1'b0, 40'd0);
    n_vec++;
    if (obs_dval !== 1'b1 || obs_sof !== 1'b1 || obs_dout !== head) begin
      n_err++;
      $display("FAIL stream_drained: dval/sof/dout got %b/%b/%h expected 1/1/%h",
               obs_dval, obs_sof, obs_dout, head);
    end
  endtask

  task automatic test_rdy_ignore();
    int n_ign;
    n_ign = 0;
    step(1'b1, 1'b0, 40'd0);
    for (int c = 0; c < 46; c++) begin
      if (c < 40) step(1'b0, 1'b1, 40'hC0_DE00_0000 + 40'(c));
      else        step(1'b0, 1'b0, 40'd0);
      if (c < 40 && !exp_rdy) n_ign++;
      n_vec++;
      if (obs_rdy !== exp_rdy || obs_dval !== exp_dval ||
          (exp_chk && (obs_dout !== exp_dout || obs_sof !== exp_sof))) begin
        n_err++;
        $display("FAIL rdy_ignore cyc %0d: rdy/dval/dout/sof got %b/%b/%h/%b expected %b/%b/%h/%b",
                 c, obs_rdy, obs_dval, obs_dout, obs_sof, exp_rdy, exp_dval, exp_dout, exp_sof);
      end
    end
    n_vec++;
    if (n_ign == 0) begin
      n_err++;
      $display("FAIL rdy_ignore_cov: got %0d ignored strobes expected >0", n_ign);
    end
  endtask

  task automatic test_random();
    int          sent, cyc;
    logic        stb;
    logic [39:0] w;
    sent = 0; cyc = 0;
    step(1'b1, 1'b0, 40'd0);
    while ((sent < 200 || exp_bits.size() >= 13) && cyc < 4000) begin
      stb = (sent < 200) && ($urandom_range(0, 99) < 30);
      w   = {8'($urandom), 32'($urandom)};
      step(1'b0, stb, w);
      if (last_acc) sent++;
      n_vec++;
      if (obs_rdy !== exp_rdy || obs_dval !== exp_dval ||
          (exp_chk && (obs_dout !== exp_dout || obs_sof !== exp_sof))) begin
        n_err++;
        $display("FAIL random cyc %0d: rdy/dval/dout/sof got %b/%b/%h/%b expected %b/%b/%h/%b",
                 cyc, obs_rdy, obs_dval, obs_dout, obs_sof, exp_rdy, exp_dval, exp_dout, exp_sof);
      end
      cyc++;
    end
    n_vec++;
    if (sent != 200) begin
      n_err++;
      $display("FAIL random_timeout: accepted %0d words expected 200", sent);
    end
  endtask

  task automatic test_mid_reset();
    logic [39:0] w3;
    logic [12:0] head;
    w3   = 40'h9B_5A17_2C4D;
    head = w3[39:27];
    step(1'b1, 1'b0, 40'd0);
    step(1'b0, 1'b1, 40'h11_2233_4455);
    step(1'b0, 1'b0, 40'd0);
    n_vec++;
    if (obs_dval !== 1'b1 || obs_dout !== 13'h0224) begin
      n_err++;
      $display("FAIL midrst_pre: dval/dout got %b/%h expected 1/0224", obs_dval, obs_dout);
    end
    step(1'b1, 1'b1, 40'hFF_EEDD_CCBB);
    n_vec++;
    if (obs_dval !== 1'b0 || obs_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_dval: dval/rdy got %b/%b expected 0/0", obs_dval, obs_rdy);
    end
    step(1'b0, 1'b1, w3);
    n_vec++;
    if (obs_rdy !== 1'b1 || obs_dval !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_rdy: rdy/dval got %b/%b expected 1/0", obs_rdy, obs_dval);
    end
    step(1'b0, 1'b0, 40'd0);
    n_vec++;
    if (obs_dval !== 1'b1 || obs_sof !== 1'b1 || obs_dout !== head) begin
      n_err++;
      $display("FAIL midrst_first: dval/sof/dout got %b/%b/%h expected 1/1/%h",
               obs_dval, obs_sof, obs_dout, head);
    end
  endtask

  // Downstream 13->40 deserializer model: realign slices on Sof into 40-bit words.
  task automatic test_frame();
    logic [39:0]  src [13];
    logic [519:0] fr;
    int           sent, cyc, k;
    logic         on;
    for (int j = 0; j < 13; j++) src[j] = {8'(j * 37 + 5), 32'hDEAD_0000 ^ 32'(j * 32'h0101_1111)};
    sent = 0; cyc = 0; k = 0; on = 1'b0; fr = '0;
    step(1'b1, 1'b0, 40'd0);
    while (k < 40 && cyc < 200) begin
      if (sent < 13) step(1'b0, 1'b1, src[sent]);
      else           step(1'b0, 1'b0, 40'd0);
      if (last_acc) sent++;
      if (obs_dval && obs_sof) on = 1'b1;
      if (obs_dval && on) begin
        fr[519 - 13 * k -: 13] = obs_dout;
        k++;
      end
      cyc++;
    end
    n_vec++;
    if (k != 40) begin
      n_err++;
      $display("FAIL frame_timeout: collected %0d slices expected 40", k);
    end
    for (int j = 0; j < 13; j++) begin
      n_vec++;
      if (fr[519 - 40 * j -: 40] !== src[j]) begin
        n_err++;
        $display("FAIL frame_word[%0d]: got %h expected %h", j, fr[519 - 40 * j -: 40], src[j]);
      end
    end
  endtask

  initial begin
    @(negedge Cin);
    test_reset();
    test_single_word();
    test_stream();
    test_rdy_ignore();
    test_random();
    test_mid_reset();
    test_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
